// File: rtl/drum_ctrl_pkg.sv
// rtl/drum_ctrl_pkg.sv - shared state encoding and defaults for the drum sequencer control
package drum_ctrl_pkg;

  localparam int STATE_W       = 3;
  localparam int NUM_STEPS_DEF = 8;

  // Encoded values are shown directly on the HEX display, so they are fixed.
  typedef enum logic [STATE_W-1:0] {
    S_INS1  = 3'd0,
    S_INS2  = 3'd1,
    S_INS3  = 3'd2,
    S_INS4  = 3'd3,
    S_BPM   = 3'd4,
    S_READY = 3'd5,
    S_PLAY  = 3'd6
  } state_e;

endpackage

// File: rtl/edge_rise.sv
// rtl/edge_rise.sv - 1-bit registered rising-edge detector with configurable reset value
module edge_rise #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Previous-cycle copy of the input; RESET_VAL=1 masks a level held through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_q <= RESET_VAL;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/drum_seq_ctrl.sv
// rtl/drum_seq_ctrl.sv - load/play sequencing FSM and step counter; optional pause via DRUM_CTRL_PAUSE_EN
module drum_seq_ctrl
  import drum_ctrl_pkg::*;
#(
  parameter int NUM_STEPS = NUM_STEPS_DEF,
  parameter int STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               play_sw,
  input  logic               beat_tick,
`ifdef DRUM_CTRL_PAUSE_EN
  input  logic               pause,
`endif
  output logic               ld_ins1,
  output logic               ld_ins2,
  output logic               ld_ins3,
  output logic               ld_ins4,
  output logic               ld_bpm,
  output logic               play,
  output logic [STEP_W-1:0]  timing,
  output logic               bar_start,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_e            state_q, state_d;
  logic [4:0]        ld_q, ld_d;
  logic [STEP_W-1:0] timing_q, timing_d;
  logic              bar_start_q, bar_start_d;
  logic              go_rise;
  logic              pause_act;

`ifdef DRUM_CTRL_PAUSE_EN
  assign pause_act = pause;
`else
  assign pause_act = 1'b0;
`endif

  // go_q resets high so a button held through reset does not fire a load.
  edge_rise #(.RESET_VAL(1'b1)) u_go_edge (
    .clk    (clk),
    .reset  (reset),
    .d_i    (go),
    .rise_o (go_rise)
  );

  // State, strobe and step-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_INS1;
      ld_q        <= '0;
      timing_q    <= '0;
      bar_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_q        <= ld_d;
      timing_q    <= timing_d;
      bar_start_q <= bar_start_d;
    end
  end

  // Next state, registered strobe requests and step-counter update.
  always_comb begin
    state_d     = state_q;
    ld_d        = '0;
    timing_d    = timing_q;
    bar_start_d = 1'b0;
    case (state_q)
      S_INS1: if (go_rise) begin state_d = S_INS2;  ld_d = 5'b00001; end
      S_INS2: if (go_rise) begin state_d = S_INS3;  ld_d = 5'b00010; end
      S_INS3: if (go_rise) begin state_d = S_INS4;  ld_d = 5'b00100; end
      S_INS4: if (go_rise) begin state_d = S_BPM;   ld_d = 5'b01000; end
      S_BPM:  if (go_rise) begin state_d = S_READY; ld_d = 5'b10000; end
      S_READY: begin
        timing_d = '0;
        // play_sw beats a coincident go so a reprogram never interrupts a start.
        if (play_sw) begin
          state_d     = S_PLAY;
          bar_start_d = 1'b1;
        end else if (go_rise) begin
          state_d = S_INS1;
        end
      end
      S_PLAY: begin
        // Stopping drops any coincident tick and parks the counter at step 0.
        if (!play_sw) begin
          state_d  = S_READY;
          timing_d = '0;
        end else if (beat_tick && !pause_act) begin
          if (timing_q == LAST_STEP) begin
            timing_d    = '0;
            bar_start_d = 1'b1;
          end else begin
            timing_d = timing_q + STEP_W'(1);
          end
        end
      end
      default: begin
        state_d  = S_INS1;
        timing_d = '0;
      end
    endcase
  end

  assign {ld_bpm, ld_ins4, ld_ins3, ld_ins2, ld_ins1} = ld_q;
  assign play      = (state_q == S_PLAY);
  assign timing    = timing_q;
  assign bar_start = bar_start_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_drum_seq_ctrl.sv
// tb/tb_drum_seq_ctrl.sv - directed self-checking bench for drum_seq_ctrl
module tb_drum_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset, go, play_sw, beat_tick;
`ifdef DRUM_CTRL_PAUSE_EN
  logic       pause;
`endif
  logic       ld_ins1, ld_ins2, ld_ins3, ld_ins4, ld_bpm;
  logic       play, bar_start;
  logic [2:0] timing;
  logic [2:0] state_o;
  logic [4:0] ld_vec;

  int tests_run    = 0;
  int tests_failed = 0;

  assign ld_vec = {ld_bpm, ld_ins4, ld_ins3, ld_ins2, ld_ins1};

  always #5 clk = ~clk;

  drum_seq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .play_sw   (play_sw),
    .beat_tick (beat_tick),
`ifdef DRUM_CTRL_PAUSE_EN
    .pause     (pause),
`endif
    .ld_ins1   (ld_ins1),
    .ld_ins2   (ld_ins2),
    .ld_ins3   (ld_ins3),
    .ld_ins4   (ld_ins4),
    .ld_bpm    (ld_bpm),
    .play      (play),
    .timing    (timing),
    .bar_start (bar_start),
    .state_o   (state_o)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic tick();
    beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    step();
  endtask

  task automatic press();
    go = 1'b1;
    repeat (3) step();
    go = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; play_sw = 1'b0; beat_tick = 1'b0;
`ifdef DRUM_CTRL_PAUSE_EN
    pause = 1'b0;
`endif
    repeat (2) step();
    tests_run++;
    if (state_o !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state_o); end
    tests_run++;
    if ({timing, play, bar_start} !== 5'd0) begin tests_failed++; $display("FAIL reset_outputs: got timing=%0d play=%0d bar=%0d expected 0", timing, play, bar_start); end
    tests_run++;
    if (ld_vec !== 5'd0) begin tests_failed++; $display("FAIL reset_strobes: got %b expected 00000", ld_vec); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_held_go();
    int seen;
    int own;
    reset = 1'b1; go = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    seen = 0;
    repeat (20) begin step(); if (ld_vec != 5'd0) seen++; end
    tests_run++;
    if (seen !== 0 || state_o !== 3'd0) begin tests_failed++; $display("FAIL held_through_reset: got strobes=%0d state=%0d expected 0/0", seen, state_o); end
    go = 1'b0;
    repeat (2) step();
    go = 1'b1;
    seen = 0; own = 0;
    repeat (20) begin
      step();
      if (ld_ins1) own++;
      if (ld_vec & 5'b11110) seen++;
    end
    go = 1'b0;
    tests_run++;
    if (own !== 1 || seen !== 0) begin tests_failed++; $display("FAIL held_go_one_strobe: got ins1=%0d other=%0d expected 1/0", own, seen); end
    tests_run++;
    if (state_o !== 3'd1) begin tests_failed++; $display("FAIL held_go_state: got %0d expected 1", state_o); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_load_sequence();
    for (int k = 0; k < 5; k++) begin
      int own, other, first, multi;
      own = 0; other = 0; first = -1; multi = 0;
      go = 1'b1;
      for (int c = 0; c < 5; c++) begin
        if (c == 3) go = 1'b0;
        step();
        if (!$onehot0(ld_vec)) multi++;
        if (ld_vec[k]) begin own++; if (first < 0) first = c; end
        if ((ld_vec & ~(5'd1 << k)) != 5'd0) other++;
      end
      tests_run++;
      if (own !== 1 || first !== 0) begin tests_failed++; $display("FAIL load_strobe_%0d: got count=%0d at=%0d expected 1 at 0", k, own, first); end
      tests_run++;
      if (other !== 0 || multi !== 0) begin tests_failed++; $display("FAIL load_other_%0d: got other=%0d multi=%0d expected 0/0", k, other, multi); end
      tests_run++;
      if (state_o !== 3'(k + 1)) begin tests_failed++; $display("FAIL load_state_%0d: got %0d expected %0d", k, state_o, k + 1); end
    end
  endtask

  task automatic test_play();
    logic [2:0] exp_t;
    play_sw = 1'b1;
    step();
    tests_run++;
    if ({state_o, play, timing, bar_start} !== {3'd6, 1'b1, 3'd0, 1'b1}) begin
      tests_failed++; $display("FAIL play_entry: got state=%0d play=%0d timing=%0d bar=%0d expected 6/1/0/1", state_o, play, timing, bar_start);
    end
    step();
    tests_run++;
    if (bar_start !== 1'b0 || timing !== 3'd0) begin tests_failed++; $display("FAIL play_entry_pulse: got bar=%0d timing=%0d expected 0/0", bar_start, timing); end
    for (int i = 0; i < 9; i++) begin
      exp_t = 3'((i + 1) % 8);
      beat_tick = 1'b1;
      step();
      beat_tick = 1'b0;
      tests_run++;
      if (timing !== exp_t || bar_start !== (exp_t == 3'd0) || ld_vec !== 5'd0) begin
        tests_failed++; $display("FAIL play_tick_%0d: got timing=%0d bar=%0d ld=%b expected %0d/%0d/00000", i, timing, bar_start, ld_vec, exp_t, exp_t == 3'd0);
      end
      step();
      tests_run++;
      if (bar_start !== 1'b0 || timing !== exp_t) begin tests_failed++; $display("FAIL play_hold_%0d: got timing=%0d bar=%0d expected %0d/0", i, timing, bar_start, exp_t); end
    end
  endtask

  task automatic test_stop();
    repeat (3) tick();
    tests_run++;
    if (timing !== 3'd4) begin tests_failed++; $display("FAIL stop_setup: got %0d expected 4", timing); end
    play_sw = 1'b0; beat_tick = 1'b1;
    step();
    beat_tick = 1'b0;
    tests_run++;
    if ({state_o, timing, play, bar_start} !== {3'd5, 3'd0, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL stop: got state=%0d timing=%0d play=%0d bar=%0d expected 5/0/0/0", state_o, timing, play, bar_start);
    end
    tick();
    tests_run++;
    if (timing !== 3'd0 || state_o !== 3'd5) begin tests_failed++; $display("FAIL ready_ignores_tick: got timing=%0d state=%0d expected 0/5", timing, state_o); end
  endtask

  task automatic test_play_priority();
    go = 1'b1; play_sw = 1'b1;
    step();
    tests_run++;
    if (state_o !== 3'd6 || ld_vec !== 5'd0 || bar_start !== 1'b1) begin
      tests_failed++; $display("FAIL play_wins: got state=%0d ld=%b bar=%0d expected 6/00000/1", state_o, ld_vec, bar_start);
    end
    go = 1'b0;
    step();
    go = 1'b1;
    step();
    tests_run++;
    if (state_o !== 3'd6 || ld_vec !== 5'd0) begin tests_failed++; $display("FAIL go_in_play: got state=%0d ld=%b expected 6/00000", state_o, ld_vec); end
    go = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_play();
    repeat (5) tick();
    tests_run++;
    if (timing !== 3'd5) begin tests_failed++; $display("FAIL midplay_setup: got %0d expected 5", timing); end
    reset = 1'b1;
    step();
    tests_run++;
    if ({state_o, timing, play, bar_start, ld_vec} !== 13'd0) begin
      tests_failed++; $display("FAIL reset_mid_play: got state=%0d timing=%0d play=%0d bar=%0d ld=%b expected all 0", state_o, timing, play, bar_start, ld_vec);
    end
    reset = 1'b0; play_sw = 1'b0;
    step();
  endtask

`ifdef DRUM_CTRL_PAUSE_EN
  task automatic test_pause();
    repeat (5) press();
    play_sw = 1'b1;
    repeat (2) step();
    repeat (3) tick();
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat_tick = 1'b1;
      step();
      beat_tick = 1'b0;
      tests_run++;
      if (timing !== 3'd3 || play !== 1'b1 || bar_start !== 1'b0) begin
        tests_failed++; $display("FAIL pause_hold_%0d: got timing=%0d play=%0d bar=%0d expected 3/1/0", i, timing, play, bar_start);
      end
      step();
    end
    pause = 1'b0;
    tick();
    tests_run++;
    if (timing !== 3'd4) begin tests_failed++; $display("FAIL pause_resume: got %0d expected 4", timing); end
    play_sw = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_held_go();
    test_load_sequence();
    test_play();
    test_stop();
    test_play_priority();
    test_reset_mid_play();
`ifdef DRUM_CTRL_PAUSE_EN
    test_pause();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
